// File: rtl/pp_column_reducer_pkg.sv
// Shared constants and types for the partial-product column reducer.
// Column widths are listed by weight: index c carries bits of weight 2^c.
// The state enum is shared so the reducer FSM and any observers agree on encoding.
package pp_col_pkg;

  localparam int NUM_COLS  = 16;
  localparam int MAX_COL_W = 45;

  localparam int COL_W [NUM_COLS] = '{18, 9, 27, 18, 36, 27, 45, 36,
                                      36, 36, 36, 36, 18, 18, 9, 9};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    ACC    = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/pp_column_reducer_popcount45.sv
// Purpose: combinational population count of a 45-bit column.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module popcount45 (
  input  logic [44:0] din,
  output logic [5:0]  cnt
);

  // Sum all column bits; 45 fits in 6 bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 45; i++) begin
      cnt = cnt + 6'(din[i]);
    end
  end

endmodule

// File: rtl/pp_column_reducer.sv
// Purpose: reduce 16 Booth partial-product columns (one per cycle) into a window sum and accumulate windows.
// Latency: accept at cycle 0, columns reduced cycles 1-16, accumulate cycle 17, out_valid from cycle 18.
// Backpressure: in_ready low while busy; result held in OUT until out_ready. Optional ACC_SAT_EN adds saturation and acc_sat.
module pp_column_reducer
  import pp_col_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [COL_W[15]-1:0]  col15,
  input  logic [COL_W[14]-1:0]  col14,
  input  logic [COL_W[13]-1:0]  col13,
  input  logic [COL_W[12]-1:0]  col12,
  input  logic [COL_W[11]-1:0]  col11,
  input  logic [COL_W[10]-1:0]  col10,
  input  logic [COL_W[9]-1:0]   col9,
  input  logic [COL_W[8]-1:0]   col8,
  input  logic [COL_W[7]-1:0]   col7,
  input  logic [COL_W[6]-1:0]   col6,
  input  logic [COL_W[5]-1:0]   col5,
  input  logic [COL_W[4]-1:0]   col4,
  input  logic [COL_W[3]-1:0]   col3,
  input  logic [COL_W[2]-1:0]   col2,
  input  logic [COL_W[1]-1:0]   col1,
  input  logic [COL_W[0]-1:0]   col0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data
`ifdef ACC_SAT_EN
  ,output logic                 acc_sat
`endif
);

  state_t                 state_q, state_d;
  logic [MAX_COL_W-1:0]   col_q [NUM_COLS];
  logic [3:0]             cnt_q;
  logic [15:0]            window_q;
  logic [ACC_W-1:0]       acc_q;
  logic                   first_q, last_q;
  logic [5:0]             pop;
  logic [15:0]            term;
  logic [ACC_W-1:0]       w;
  logic [ACC_W-1:0]       acc_next;
  logic                   accept;

  assign accept = (state_q == IDLE) && in_valid;

  // Only one popcount: the column for the current cycle is selected by the counter.
  popcount45 u_popcount (
    .din (col_q[cnt_q]),
    .cnt (pop)
  );

  // Weighted contribution of this column; bits shifted past 2^15 drop (window is mod 2^16).
  assign term = 16'(pop) << cnt_q;

  // Window sum is a signed 16-bit quantity, sign-extended into the accumulator.
  assign w = ACC_W'($signed(window_q));

`ifdef ACC_SAT_EN
  logic [ACC_W:0] ext_sum;
  logic           ovf;
  assign ext_sum = {acc_q[ACC_W-1], acc_q} + {w[ACC_W-1], w};
  assign ovf     = ext_sum[ACC_W] != ext_sum[ACC_W-1];

  // Saturating accumulate: clamp toward the sign of the true (wide) sum.
  always_comb begin
    acc_next = ext_sum[ACC_W-1:0];
    if (first_q) begin
      acc_next = w;
    end else if (ovf) begin
      acc_next = ext_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Sticky overflow flag, cleared when a new accumulation starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_sat <= 1'b0;
    end else if (accept && in_first) begin
      acc_sat <= 1'b0;
    end else if (state_q == ACC && !first_q && ovf) begin
      acc_sat <= 1'b1;
    end
  end
`else
  // Wrapping two's-complement accumulate.
  always_comb begin
    acc_next = acc_q + w;
    if (first_q) begin
      acc_next = w;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = REDUCE;
      end
      REDUCE: begin
        if (cnt_q == 4'd15) state_d = ACC;
      end
      ACC: begin
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture columns, reduce one column per cycle, accumulate, hold result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_COLS; c++) col_q[c] <= '0;
      cnt_q    <= '0;
      window_q <= '0;
      acc_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      out_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            col_q[0]  <= MAX_COL_W'(col0);
            col_q[1]  <= MAX_COL_W'(col1);
            col_q[2]  <= MAX_COL_W'(col2);
            col_q[3]  <= MAX_COL_W'(col3);
            col_q[4]  <= MAX_COL_W'(col4);
            col_q[5]  <= MAX_COL_W'(col5);
            col_q[6]  <= MAX_COL_W'(col6);
            col_q[7]  <= MAX_COL_W'(col7);
            col_q[8]  <= MAX_COL_W'(col8);
            col_q[9]  <= MAX_COL_W'(col9);
            col_q[10] <= MAX_COL_W'(col10);
            col_q[11] <= MAX_COL_W'(col11);
            col_q[12] <= MAX_COL_W'(col12);
            col_q[13] <= MAX_COL_W'(col13);
            col_q[14] <= MAX_COL_W'(col14);
            col_q[15] <= MAX_COL_W'(col15);
            first_q   <= in_first;
            last_q    <= in_last;
            cnt_q     <= '0;
            window_q  <= '0;
          end
        end
        REDUCE: begin
          window_q <= window_q + term;
          cnt_q    <= cnt_q + 4'd1;
        end
        ACC: begin
          acc_q <= acc_next;
          if (last_q) out_data <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule
